// File: rtl/k4_pkg.sv
// k4_pkg: opcodes, FSM states and instruction-field constants shared by the K4 core
package k4_pkg;
  localparam int K4_IW      = 16;
  localparam int K4_OP_LSB  = 12;
  localparam int K4_RD_LSB  = 10;
  localparam int K4_RS_LSB  = 8;
  localparam int K4_IMM_LSB = 0;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_MOV  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_OUT  = 4'd5,
    OP_JMP  = 4'd6,
    OP_JC   = 4'd7,
    OP_JZ   = 4'd8,
    OP_HALT = 4'd9
  } k4_op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} k4_state_e;
endpackage

// File: rtl/k4_alu.sv
// k4_alu: DW-bit add/subtract with carry-out and zero detect
//   a, b   : operands
//   sub    : 1 = a + ~b + 1 (carry = no borrow), 0 = a + b
//   result : DW-bit modulo result; carry: carry-out; zero: result == 0
module k4_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);
  logic [DW:0] sum;
  assign sum    = {1'b0, a} + {1'b0, sub ? ~b : b} + {{DW{1'b0}}, sub};
  assign result = sum[DW-1:0];
  assign carry  = sum[DW];
  assign zero   = result == '0;
endmodule

// File: rtl/k4_core.sv
// k4_core: four-register microcore with writable instruction memory and IDLE/RUN/HALT control
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : begin at pc 0 (IDLE or HALT only)
//   step                : only with K4_CORE_STEP_EN; gates execution in RUN
//   prog_we/addr/data   : instruction-memory write port (ignored in RUN)
//   out_data, out_valid : OUT result and its one-cycle strobe
//   halted, busy, pc    : FSM in HALT, FSM in RUN, program counter
// Optional feature macro: K4_CORE_STEP_EN
module k4_core
  import k4_pkg::*;
#(
  parameter  int DW         = 8,
  parameter  int IMEM_DEPTH = 16,
  localparam int PCW        = $clog2(IMEM_DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
`ifdef K4_CORE_STEP_EN
  input  logic             step,
`endif
  input  logic             prog_we,
  input  logic [PCW-1:0]   prog_addr,
  input  logic [K4_IW-1:0] prog_data,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  output logic             halted,
  output logic             busy,
  output logic [PCW-1:0]   pc
);
  k4_state_e        state, state_nxt;
  logic [K4_IW-1:0] imem [IMEM_DEPTH];
  logic [DW-1:0]    regs [4];
  logic [K4_IW-1:0] instr;
  k4_op_e           op;
  logic [1:0]       rd, rs;
  logic [7:0]       imm;
  logic [DW-1:0]    rd_val, rs_val, alu_res, reg_wd;
  logic             alu_c, alu_z, c_q, z_q;
  logic             exec, reg_we, flag_we, flag_clr, out_we;
  logic [PCW-1:0]   pc_nxt;
  assign instr  = imem[pc];
  assign op     = k4_op_e'(instr[K4_OP_LSB +: 4]);
  assign rd     = instr[K4_RD_LSB +: 2];
  assign rs     = instr[K4_RS_LSB +: 2];
  assign imm    = instr[K4_IMM_LSB +: 8];
  assign rd_val = regs[rd];
  assign rs_val = regs[rs];
  assign halted = state == S_HALT;
  assign busy   = state == S_RUN;
`ifdef K4_CORE_STEP_EN
  assign exec = busy && step;
`else
  assign exec = busy;
`endif
  k4_alu #(.DW(DW)) u_alu (
    .a(rd_val),
    .b(rs_val),
    .sub(op == OP_SUB),
    .result(alu_res),
    .carry(alu_c),
    .zero(alu_z)
  );
  // The fetched word is decoded only while executing; everything else holds.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    reg_we    = 1'b0;
    reg_wd    = alu_res;
    flag_we   = 1'b0;
    flag_clr  = 1'b0;
    out_we    = 1'b0;
    if (state != S_RUN) begin
      if (start) begin
        state_nxt = S_RUN;
        pc_nxt    = '0;
        flag_clr  = 1'b1;
      end
    end else if (exec) begin
      pc_nxt = pc + 1'b1;
      case (op)
        OP_LDI: begin
          reg_we = 1'b1;
          reg_wd = DW'(imm);
        end
        OP_MOV: begin
          reg_we = 1'b1;
          reg_wd = rs_val;
        end
        OP_ADD, OP_SUB: begin
          reg_we  = 1'b1;
          flag_we = 1'b1;
        end
        OP_OUT:  out_we = 1'b1;
        OP_JMP:  pc_nxt = imm[PCW-1:0];
        OP_JC:   pc_nxt = c_q ? imm[PCW-1:0] : pc + 1'b1;
        OP_JZ:   pc_nxt = z_q ? imm[PCW-1:0] : pc + 1'b1;
        OP_HALT: begin
          state_nxt = S_HALT;
          pc_nxt    = pc;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      out_valid <= out_we;
      if (out_we) out_data <= rd_val;
      if (reg_we) regs[rd] <= reg_wd;
      if (flag_clr) begin
        c_q <= 1'b0;
        z_q <= 1'b0;
      end else if (flag_we) begin
        c_q <= alu_c;
        z_q <= alu_z;
      end
    end
  end
  // Program store survives reset so a loaded program can be rerun.
  always_ff @(posedge clk) begin
    if (prog_we && state != S_RUN) imem[prog_addr] <= prog_data;
  end
endmodule

// File: tb/tb_k4_core.sv
// tb_k4_core: directed self-checking bench for k4_core
module tb_k4_core;
  import k4_pkg::*;
  localparam int DW  = 8;
  localparam int D   = 16;
  localparam int PCW = 4;
  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           prog_we = 1'b0;
  logic [PCW-1:0] prog_addr = '0;
  logic [15:0]    prog_data = '0;
  logic [DW-1:0]  out_data;
  logic           out_valid, halted, busy;
  logic [PCW-1:0] pc;
`ifdef K4_CORE_STEP_EN
  logic step = 1'b1;
`endif
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  k4_core #(.DW(DW), .IMEM_DEPTH(D)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
`ifdef K4_CORE_STEP_EN
    .step(step),
`endif
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .halted(halted),
    .busy(busy),
    .pc(pc)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input logic [15:0] d);
    prog_we = 1'b1;
    prog_addr = PCW'(a);
    prog_data = d;
    tick(1);
    prog_we = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  function automatic logic [15:0] ins(input logic [3:0] op, input int rd, input int rs, input int imm);
    return {op, 2'(rd), 2'(rs), 8'(imm)};
  endfunction
  initial begin
    tick(2);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc", pc, 0);
    reset_n = 1'b1;
    tick(1);
    // overflow: ADD wraps to 0, sets C and Z, JC taken
    wr(0, ins(OP_LDI, 0, 0, 8'hFF));
    wr(1, ins(OP_LDI, 1, 0, 8'h01));
    wr(2, ins(OP_ADD, 0, 1, 0));
    wr(3, ins(OP_JC, 0, 0, 7));
    wr(4, ins(OP_HALT, 0, 0, 0));
    wr(5, ins(OP_HALT, 0, 0, 0));
    wr(6, ins(OP_HALT, 0, 0, 0));
    wr(7, ins(OP_OUT, 0, 0, 0));
    wr(8, ins(OP_HALT, 0, 0, 0));
    go();
    chk("ovf_busy", busy, 1);
    chk("ovf_pc0", pc, 0);
    tick(3);
    chk("ovf_r0", dut.regs[0], 8'h00);
    chk("ovf_c", dut.c_q, 1);
    chk("ovf_z", dut.z_q, 1);
    tick(1);
    chk("ovf_jc_taken", pc, 7);
    tick(1);
    chk("ovf_out_valid", out_valid, 1);
    chk("ovf_out_data", out_data, 8'h00);
    tick(1);
    chk("ovf_halted", halted, 1);
    chk("ovf_c_held", dut.c_q, 1);
    // basic program: 5 + 3
    wr(0, ins(OP_LDI, 0, 0, 5));
    wr(1, ins(OP_LDI, 1, 0, 3));
    wr(2, ins(OP_ADD, 0, 1, 0));
    wr(3, ins(OP_OUT, 0, 0, 0));
    wr(4, ins(OP_HALT, 0, 0, 0));
    go();
    chk("p1_busy", busy, 1);
    chk("p1_halted_low", halted, 0);
    chk("p1_c_cleared", dut.c_q, 0);
    chk("p1_z_cleared", dut.z_q, 0);
    tick(3);
    chk("p1_no_early_valid", out_valid, 0);
    tick(1);
    chk("p1_out_valid", out_valid, 1);
    chk("p1_out_data", out_data, 8'h08);
    chk("p1_busy_t5", busy, 1);
    tick(1);
    chk("p1_valid_pulse", out_valid, 0);
    chk("p1_halted", halted, 1);
    chk("p1_busy_low", busy, 0);
    chk("p1_c", dut.c_q, 0);
    chk("p1_z", dut.z_q, 0);
    tick(2);
    chk("p1_halt_holds", halted, 1);
    // restart: registers survive HALT -> RUN
    wr(0, ins(OP_OUT, 0, 0, 0));
    wr(1, ins(OP_HALT, 0, 0, 0));
    go();
    tick(1);
    chk("rs_out_valid", out_valid, 1);
    chk("rs_out_data", out_data, 8'h08);
    tick(1);
    chk("rs_halted", halted, 1);
    // SUB equality then inequality
    wr(0, ins(OP_LDI, 2, 0, 9));
    wr(1, ins(OP_LDI, 3, 0, 9));
    wr(2, ins(OP_SUB, 2, 3, 0));
    wr(3, ins(OP_JZ, 0, 0, 6));
    wr(4, ins(OP_HALT, 0, 0, 0));
    wr(5, ins(OP_HALT, 0, 0, 0));
    wr(6, ins(OP_HALT, 0, 0, 0));
    go();
    tick(3);
    chk("subeq_z", dut.z_q, 1);
    chk("subeq_c", dut.c_q, 1);
    tick(1);
    chk("subeq_jz_taken", pc, 6);
    tick(1);
    chk("subeq_halted", halted, 1);
    wr(1, ins(OP_LDI, 3, 0, 10));
    go();
    tick(3);
    chk("subne_z", dut.z_q, 0);
    chk("subne_c", dut.c_q, 0);
    chk("subne_r2", dut.regs[2], 8'hFF);
    tick(1);
    chk("subne_fallthru", pc, 4);
    tick(1);
    chk("subne_halted", halted, 1);
    // wrap with all NOPs; write and start during RUN are ignored
    for (int i = 0; i < D; i++) wr(i, 16'h0000);
    go();
    for (int i = 0; i < 20; i++) begin
      chk("wrap_pc", pc, i % D);
      chk("wrap_busy", busy, 1);
      tick(1);
    end
    prog_we = 1'b1;
    prog_addr = '0;
    prog_data = ins(OP_HALT, 0, 0, 0);
    start = 1'b1;
    tick(1);
    prog_we = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("prot_pc", pc, (5 + i) % D);
      chk("prot_busy", busy, 1);
      tick(1);
    end
    // asynchronous reset mid-run
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_halted", halted, 0);
    chk("arst_pc", pc, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_r2", dut.regs[2], 0);
    chk("arst_c", dut.c_q, 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    // write and start in the same IDLE cycle: new word is instruction 0
    prog_we = 1'b1;
    prog_addr = '0;
    prog_data = ins(OP_HALT, 0, 0, 0);
    start = 1'b1;
    tick(1);
    prog_we = 1'b0;
    start = 1'b0;
    chk("same_busy", busy, 1);
    tick(1);
    chk("same_halted", halted, 1);
    chk("same_busy_low", busy, 0);
`ifdef K4_CORE_STEP_EN
    wr(0, ins(OP_NOP, 0, 0, 0));
    wr(1, ins(OP_NOP, 0, 0, 0));
    wr(2, ins(OP_LDI, 1, 0, 8'h5A));
    wr(3, ins(OP_OUT, 1, 0, 0));
    wr(4, ins(OP_HALT, 0, 0, 0));
    step = 1'b0;
    go();
    tick(3);
    chk("step_hold0", pc, 0);
    for (int i = 1; i <= 3; i++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      chk("step_adv", pc, i);
      tick(2);
      chk("step_hold", pc, i);
    end
    chk("step_r1", dut.regs[1], 8'h5A);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    chk("step_out_valid", out_valid, 1);
    chk("step_out_data", out_data, 8'h5A);
    tick(1);
    chk("step_valid_low", out_valid, 0);
    chk("step_busy", busy, 1);
    step = 1'b1;
    tick(1);
    chk("step_halted", halted, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
